// File: rtl/brownout_ctrl_pkg.sv
// Shared types and defaults for the brown-out detector controller.
package brownout_ctrl_pkg;

    localparam int unsigned TRIP_W            = 3;
    localparam int unsigned EVT_W             = 8;
    localparam int unsigned DEF_SETTLE_CYCLES = 64;
    localparam int unsigned DEF_HOLD_CYCLES   = 256;
    localparam int unsigned DEF_DEB_CYCLES    = 4;
    localparam int unsigned DEF_CNT_W         = 16;

    typedef enum logic [2:0] {
        StOff      = 3'd0,
        StSettle   = 3'd1,
        StArmed    = 3'd2,
        StBrownout = 3'd3,
        StHold     = 3'd4
    } bo_state_t;

    function automatic logic holds_reset(bo_state_t s);
        return (s == StBrownout) || (s == StHold);
    endfunction

endpackage

// File: rtl/brownout_ctrl_debounce.sv
// Two-flop synchronizer followed by a run-length filter: a new level is accepted only after
// DEB_CYCLES consecutive synchronized samples that differ from the current one.
module brownout_ctrl_debounce
    import brownout_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEF_DEB_CYCLES
) (
    input  logic clk,
    input  logic resetb,
    input  logic async_i,
    output logic level_o
);

    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CntLast = CW'(DEB_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= async_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level_o = level_q;

endmodule

// File: rtl/brownout_ctrl.sv
// Brown-out detector sequencer: enable/settle, safe trip-code updates, debounced reset request.
// Optional BROWNOUT_CTRL_EVTCNT_EN adds a saturating brown-out event counter on evt_cnt.
module brownout_ctrl
    import brownout_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              cfg_ena,
    input  logic [TRIP_W-1:0] cfg_otrip,
    input  logic [TRIP_W-1:0] cfg_vtrip,
    input  logic [1:0]        cfg_force_osc,
    input  logic              clr,
    input  logic              brout_filt,
    input  logic              vunder,
    input  logic              timed_out,
    output logic              ena,
    output logic [TRIP_W-1:0] otrip,
    output logic [TRIP_W-1:0] vtrip,
    output logic              force_ena_rc_osc,
    output logic              force_dis_rc_osc,
    output logic              rst_req,
    output logic              vunder_sync,
    output logic              irq,
    output logic              timeout_seen,
`ifdef BROWNOUT_CTRL_EVTCNT_EN
    output logic [EVT_W-1:0]  evt_cnt,
`endif
    output logic [2:0]        state
);

    localparam logic [CNT_W-1:0] SettleLoad = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HoldLoad   = CNT_W'(HOLD_CYCLES - 1);

    bo_state_t         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_dec;
    logic [TRIP_W-1:0] otrip_q, otrip_d, vtrip_q, vtrip_d;
    logic              ena_q, rst_req_q, irq_q;
    logic              force_ena_q, force_dis_q;
    logic              timeout_seen_q, timeout_seen_d;
    logic              vu_s1_q, vu_s2_q;
    logic              to_s1_q, to_s2_q, to_s3_q;
    logic              brout_deb;
    logic              trip_chg;
    logic              bo_entry;

    brownout_ctrl_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_brout_deb (
        .clk    (clk),
        .resetb (resetb),
        .async_i(brout_filt),
        .level_o(brout_deb)
    );

    assign trip_chg = (cfg_otrip != otrip_q) || (cfg_vtrip != vtrip_q);
    // Saturate at zero so a stale count can never wrap into a huge delay.
    assign cnt_dec  = (cnt_q == '0) ? '0 : cnt_q - 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        otrip_d = otrip_q;
        vtrip_d = vtrip_q;

        unique case (state_q)
            StOff: begin
                otrip_d = cfg_otrip;
                vtrip_d = cfg_vtrip;
                if (cfg_ena) begin
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end
            end
            StSettle: begin
                if (trip_chg) begin
                    otrip_d = cfg_otrip;
                    vtrip_d = cfg_vtrip;
                    cnt_d   = SettleLoad;
                end else if (cnt_q == '0) begin
                    state_d = StArmed;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            StArmed: begin
                // A live brown-out outranks a pending code change.
                if (brout_deb) begin
                    state_d = StBrownout;
                end else if (trip_chg) begin
                    otrip_d = cfg_otrip;
                    vtrip_d = cfg_vtrip;
                    state_d = StSettle;
                    cnt_d   = SettleLoad;
                end
            end
            StBrownout: begin
                if (!brout_deb) begin
                    state_d = StHold;
                    cnt_d   = HoldLoad;
                end
            end
            StHold: begin
                if (brout_deb) begin
                    state_d = StBrownout;
                end else if (cnt_q == '0) begin
                    state_d = StArmed;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            default: begin
                state_d = StOff;
            end
        endcase

        if (!cfg_ena) begin
            state_d = StOff;
            cnt_d   = '0;
            if (state_q != StOff) begin
                otrip_d = otrip_q;
                vtrip_d = vtrip_q;
            end
        end
    end

    assign bo_entry       = (state_d == StBrownout) && (state_q != StBrownout);
    // A set on the same cycle as a clear must not be lost.
    assign timeout_seen_d = (to_s2_q & ~to_s3_q) | (timeout_seen_q & ~clr);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q        <= StOff;
            cnt_q          <= '0;
            otrip_q        <= '0;
            vtrip_q        <= '0;
            ena_q          <= 1'b0;
            rst_req_q      <= 1'b0;
            irq_q          <= 1'b0;
            force_ena_q    <= 1'b0;
            force_dis_q    <= 1'b0;
            timeout_seen_q <= 1'b0;
            vu_s1_q        <= 1'b0;
            vu_s2_q        <= 1'b0;
            to_s1_q        <= 1'b0;
            to_s2_q        <= 1'b0;
            to_s3_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            otrip_q        <= otrip_d;
            vtrip_q        <= vtrip_d;
            ena_q          <= (state_d != StOff);
            rst_req_q      <= holds_reset(state_d);
            irq_q          <= bo_entry;
            force_ena_q    <= cfg_force_osc[0];
            force_dis_q    <= cfg_force_osc[1];
            timeout_seen_q <= timeout_seen_d;
            vu_s1_q        <= vunder;
            vu_s2_q        <= vu_s1_q;
            to_s1_q        <= timed_out;
            to_s2_q        <= to_s1_q;
            to_s3_q        <= to_s2_q;
        end
    end

`ifdef BROWNOUT_CTRL_EVTCNT_EN
    logic [EVT_W-1:0] evt_cnt_q, evt_cnt_d;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (clr) begin
            evt_cnt_d = '0;
        end else if (bo_entry && (evt_cnt_q != '1)) begin
            evt_cnt_d = evt_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

    assign state            = state_q;
    assign ena              = ena_q;
    assign otrip            = otrip_q;
    assign vtrip            = vtrip_q;
    assign force_ena_rc_osc = force_ena_q;
    assign force_dis_rc_osc = force_dis_q;
    assign rst_req          = rst_req_q;
    assign vunder_sync      = vu_s2_q;
    assign irq              = irq_q;
    assign timeout_seen     = timeout_seen_q;

endmodule
